mul_inv_divider: RTL and testbench



---
 rtl/mul_inv_divider.sv | 109 ++++++++++
 tb/tb_mul_inv_divider.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mul_inv_divider.sv
// mul_inv_divider: sequential 8/4 restoring divider, one quotient bit per clock, push-button start.
module mul_inv_divider (
  input  logic        CLOCK_50,
  input  logic [1:0]  KEY,
  input  logic [11:0] SW,
  output logic [14:0] LEDR,
  output logic [0:6]  HEX0,
  output logic [0:6]  HEX1,
  output logic [0:6]  HEX2,
  output logic [0:6]  HEX3,
  output logic [0:6]  HEX4,
  output logic [0:6]  HEX5
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] key_q;
  logic [7:0] a_q, a_d, qw_q, qw_d, q_q, q_d;
  logic [3:0] b_q, b_d, r_q, r_d;
  logic [4:0] w_q, w_d, w_sh;
  logic [2:0] cnt_q, cnt_d;
  logic       err_q, err_d, start, ge;
  // key_q = {previous, synced, first stage}; a press is a synced 1->0 transition
  assign start = key_q[2] & ~key_q[1];
  always_ff @(posedge CLOCK_50 or negedge KEY[0]) begin
    if (!KEY[0]) begin
      state_q <= IDLE;
      key_q   <= 3'b111;
      a_q     <= '0;
      b_q     <= '0;
      w_q     <= '0;
      qw_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= {key_q[1:0], KEY[1]};
      a_q     <= a_d;
      b_q     <= b_d;
      w_q     <= w_d;
      qw_q    <= qw_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    w_d     = w_q;
    qw_d    = qw_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    err_d   = err_q;
    w_sh    = {w_q[3:0], a_q[cnt_q]};
    ge      = w_sh >= {1'b0, b_q};
    if (state_q == CALC) begin
      w_d   = ge ? w_sh - {1'b0, b_q} : w_sh;
      qw_d  = {qw_q[6:0], ge};
      cnt_d = cnt_q - 3'd1;
      if (cnt_q == 3'd0) begin
        state_d = DONE;
        q_d     = qw_d;
        r_d     = w_d[3:0];
      end
    end else if (start) begin
      a_d     = SW[7:0];
      b_d     = SW[11:8];
      w_d     = '0;
      qw_d    = '0;
      cnt_d   = 3'd7;
      err_d   = SW[11:8] == 4'd0;
      state_d = err_d ? DONE : CALC;
      q_d     = err_d ? 8'hFF : q_q;
      r_d     = err_d ? 4'hF : r_q;
    end
  end
  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
  endfunction
  assign LEDR = {err_q, state_q == DONE, state_q == CALC, r_q, q_q};
  assign HEX0 = seg(SW[11:8]);
  assign HEX2 = seg(SW[3:0]);
  assign HEX3 = seg(SW[7:4]);
  assign HEX4 = seg(q_q[3:0]);
  assign HEX5 = seg(q_q[7:4]);
  assign HEX1 = seg(r_q);
endmodule

// File: tb/tb_mul_inv_divider.sv
// tb_mul_inv_divider: randomized and directed checks of the divider against plain integer division.
module tb_mul_inv_divider;
  logic        CLOCK_50 = 1'b0;
  logic [1:0]  KEY = 2'b10;
  logic [11:0] SW = '0;
  logic [14:0] LEDR;
  logic [0:6]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  int checks = 0, passed = 0;
  logic [6:0] seg_ref [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  always #5 CLOCK_50 = ~CLOCK_50;

  mul_inv_divider dut (.CLOCK_50(CLOCK_50), .KEY(KEY), .SW(SW), .LEDR(LEDR),
                       .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Press start just after a negedge; sample n = 1..11 negedges later. The pulse falls in the cycle
  // before sample 3, so busy covers samples 3..10 and the result is due at sample 11 (B=0: sample 3).
  task automatic op(input int a, input int b, input bit disturb, input bit hex);
    int busy_n, done_at, eq, er, ee;
    eq = (b == 0) ? 255 : a / b;
    er = (b == 0) ? 15 : a % b;
    ee = (b == 0) ? 1 : 0;
    busy_n = 0;
    done_at = 0;
    SW = {b[3:0], a[7:0]};
    @(negedge CLOCK_50);
    #1 KEY[1] = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      @(negedge CLOCK_50);
      if (n == 2) KEY[1] = 1'b1;
      if (disturb && n == 6) begin SW = {4'd1, 8'd0}; KEY[1] = 1'b0; end
      if (disturb && n == 8) KEY[1] = 1'b1;
      busy_n += int'(LEDR[12]);
      if (n > 2 && LEDR[13] && done_at == 0) done_at = n;
    end
    chk("busy_cycles", busy_n, b == 0 ? 0 : 8);
    chk("done_cycle", done_at, b == 0 ? 3 : 11);
    chk("quotient", int'(LEDR[7:0]), eq);
    chk("remainder", int'(LEDR[11:8]), er);
    chk("err", int'(LEDR[14]), ee);
    if (b != 0) begin
      chk("invariant_a", int'(LEDR[7:0]) * b + int'(LEDR[11:8]), a);
      chk("invariant_r_lt_b", int'(int'(LEDR[11:8]) < b), 1);
    end
    if (hex) begin
      chk("hex5", int'(HEX5), int'(seg_ref[eq / 16]));
      chk("hex4", int'(HEX4), int'(seg_ref[eq % 16]));
      chk("hex1", int'(HEX1), int'(seg_ref[er]));
      chk("hex0", int'(HEX0), int'(seg_ref[SW[11:8]]));
      chk("hex3", int'(HEX3), int'(seg_ref[SW[7:4]]));
      chk("hex2", int'(HEX2), int'(seg_ref[SW[3:0]]));
    end
    repeat (3) @(negedge CLOCK_50);
  endtask

  initial begin
    int busy_n, base, stride, idx;
    repeat (3) @(negedge CLOCK_50);
    chk("reset_ledr", int'(LEDR), 0);
    chk("reset_hex1", int'(HEX1), int'(seg_ref[0]));
    chk("reset_hex4", int'(HEX4), int'(seg_ref[0]));
    chk("reset_hex5", int'(HEX5), int'(seg_ref[0]));
    KEY = 2'b11;
    repeat (3) @(negedge CLOCK_50);
    chk("idle_ledr", int'(LEDR), 0);
    op(200, 7, 1'b0, 1'b1);
    op(255, 1, 1'b0, 1'b1);
    op(3, 9, 1'b0, 1'b1);
    op(15, 0, 1'b0, 1'b1);
    op(15, 5, 1'b0, 1'b0);
    op(100, 3, 1'b1, 1'b0);
    // Held button: exactly one operation.
    SW = {4'd3, 8'd5};
    busy_n = 0;
    #1 KEY[1] = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge CLOCK_50);
      busy_n += int'(LEDR[12]);
    end
    KEY[1] = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    chk("hold_busy_cycles", busy_n, 8);
    chk("hold_quotient", int'(LEDR[7:0]), 1);
    chk("hold_remainder", int'(LEDR[11:8]), 2);
    // Reset in the middle of a calculation.
    SW = {4'd7, 8'd200};
    #1 KEY[1] = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      @(negedge CLOCK_50);
      if (n == 2) KEY[1] = 1'b1;
    end
    chk("pre_abort_busy", int'(LEDR[12]), 1);
    #1 KEY[0] = 1'b0;
    #1 chk("abort_ledr", int'(LEDR), 0);
    chk("abort_hex4", int'(HEX4), int'(seg_ref[0]));
    chk("abort_hex5", int'(HEX5), int'(seg_ref[0]));
    chk("abort_hex1", int'(HEX1), int'(seg_ref[0]));
    repeat (2) @(negedge CLOCK_50);
    chk("abort_hold_ledr", int'(LEDR), 0);
    KEY[0] = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    chk("abort_no_done", int'(LEDR), 0);
    op(16, 4, 1'b0, 1'b1);
    // Every (A,B) pair, in a random order.
    base = int'($urandom_range(0, 4095));
    stride = int'($urandom_range(0, 2047)) * 2 + 1;
    for (int i = 0; i < 4096; i++) begin
      idx = (base + i * stride) % 4096;
      op(idx % 256, idx / 256, 1'b0, 1'b0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
